branch_resolve_bht: RTL and testbench

//  Parametrised successor to the ID/EX branch detector. All conditional branches (BEQ..BGEU) resolve in EX.
//  A PC-indexed table of 2-bit saturating counters predicts direction in IF.
//  The block drives PC redirect and IF/ID flush on a mispredict or on a JAL/JALR.
//  It also keeps a saturating mispredict statistics counter. Sits between the IF PC mux and the EX stage.

---
 rtl/branch_resolve_bht_pkg.sv | 31 +++
 rtl/branch_resolve_bht_if.sv | 35 +++
 rtl/branch_resolve_bht_counter_array.sv | 37 +++
 rtl/branch_resolve_bht.sv | 107 ++++++++++
 tb/tb_branch_resolve_bht.sv | 120 ++++++++++++
 5 files changed

// File: rtl/branch_resolve_bht_pkg.sv
// Shared branch-resolution definitions: funct3 encodings, 2-bit counter
// states and the saturating counter update used by the BHT.
package branch_pkg;

  typedef logic [1:0] ctr_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam ctr_t SNT = 2'd0;
  localparam ctr_t WNT = 2'd1;
  localparam ctr_t WT  = 2'd2;
  localparam ctr_t ST  = 2'd3;

  // Saturating 2-bit direction counter step
  function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
    ctr_t res;
    res = ctr;
    if (taken) begin
      if (ctr != ST) res = ctr + 2'd1;
    end else begin
      if (ctr != SNT) res = ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_resolve_bht_if.sv
// IF/EX-side bundle for the branch resolver: prediction lookup, EX
// instruction info, and the redirect/flush/statistics response.
interface branch_resolve_bht_if #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 16
);
  logic [XLEN-1:0]  if_pc;
  logic             pred_taken;
  logic             ex_valid;
  logic             ex_branch;
  logic             ex_jump;
  logic [2:0]       ex_funct3;
  logic [XLEN-1:0]  ex_rs1;
  logic [XLEN-1:0]  ex_rs2;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_target;
  logic             ex_pred_taken;
  logic             hazard;
  logic             redirect;
  logic [XLEN-1:0]  redirect_pc;
  logic             flush;
  logic [CNT_W-1:0] mispredict_cnt;

  modport master (
    output if_pc, ex_valid, ex_branch, ex_jump, ex_funct3, ex_rs1, ex_rs2,
           ex_pc, ex_target, ex_pred_taken, hazard,
    input  pred_taken, redirect, redirect_pc, flush, mispredict_cnt
  );

  modport slave (
    input  if_pc, ex_valid, ex_branch, ex_jump, ex_funct3, ex_rs1, ex_rs2,
           ex_pc, ex_target, ex_pred_taken, hazard,
    output pred_taken, redirect, redirect_pc, flush, mispredict_cnt
  );
endinterface

// File: rtl/branch_resolve_bht_counter_array.sv
// Table of 2-bit saturating counters: async read (IF), read-modify-write
// on the clock edge (EX), async clear to weakly-not-taken.
module bht_counter_array
  import branch_pkg::*;
#(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output ctr_t             rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  ctr_t ctr_q [ENTRIES];
  ctr_t ctr_d [ENTRIES];

  // Reads see the registered value only, so a same-index write shows up next cycle
  assign rd_ctr = ctr_q[rd_idx];

  always_comb begin
    ctr_d = ctr_q;
    if (wr_en) ctr_d[wr_idx] = sat_update(ctr_q[wr_idx], wr_taken);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) ctr_q[i] <= WNT;
    end else begin
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: rtl/branch_resolve_bht.sv
// EX-stage branch resolver with BHT direction predictor: compares operands,
// drives same-cycle redirect/flush, trains the table and counts mispredicts.
module branch_resolve_bht
  import branch_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  branch_resolve_bht_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  logic             act_taken;
  logic             f3_ok;
  logic             br_valid;
  logic             mispredict;
  logic             jump_fire;
  logic             redirect_c;
  logic [XLEN-1:0]  redirect_pc_c;
  logic [XLEN-1:0]  pc_plus4;
  logic             tbl_wr_en;
  logic             cnt_inc;
  ctr_t             rd_ctr;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [CNT_W-1:0] mispredict_cnt_q;
  logic [CNT_W-1:0] mispredict_cnt_d;

  assign rd_idx = bus.if_pc[IDX_W+1:2];
  assign wr_idx = bus.ex_pc[IDX_W+1:2];

  bht_counter_array #(
    .ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (rd_idx),
    .rd_ctr   (rd_ctr),
    .wr_en    (tbl_wr_en),
    .wr_idx   (wr_idx),
    .wr_taken (act_taken)
  );

  // Branch condition; reserved funct3 values resolve not-taken and never train
  always_comb begin
    act_taken = 1'b0;
    f3_ok     = 1'b1;
    case (bus.ex_funct3)
      F3_BEQ:  act_taken = (bus.ex_rs1 == bus.ex_rs2);
      F3_BNE:  act_taken = (bus.ex_rs1 != bus.ex_rs2);
      F3_BLT:  act_taken = ($signed(bus.ex_rs1) <  $signed(bus.ex_rs2));
      F3_BGE:  act_taken = ($signed(bus.ex_rs1) >= $signed(bus.ex_rs2));
      F3_BLTU: act_taken = (bus.ex_rs1 <  bus.ex_rs2);
      F3_BGEU: act_taken = (bus.ex_rs1 >= bus.ex_rs2);
      default: f3_ok     = 1'b0;
    endcase
  end

  assign br_valid   = bus.ex_valid & bus.ex_branch;
  assign mispredict = br_valid & (act_taken != bus.ex_pred_taken);
  assign jump_fire  = bus.ex_valid & bus.ex_jump;
  assign pc_plus4   = bus.ex_pc + XLEN'(4);

  // Redirect mux: jump wins over branch; reset forces the quiet values
  always_comb begin
    redirect_c    = 1'b0;
    redirect_pc_c = pc_plus4;
    if (!bus.hazard) begin
      if (jump_fire) begin
        redirect_c    = 1'b1;
        redirect_pc_c = bus.ex_target;
      end else if (mispredict) begin
        redirect_c    = 1'b1;
        redirect_pc_c = act_taken ? bus.ex_target : pc_plus4;
      end
    end
    if (!rst_n) begin
      redirect_c    = 1'b0;
      redirect_pc_c = '0;
    end
  end

  assign tbl_wr_en = br_valid & f3_ok & ~bus.hazard;
  assign cnt_inc   = mispredict & f3_ok & ~bus.hazard & ~jump_fire;

  always_comb begin
    mispredict_cnt_d = mispredict_cnt_q;
    if (cnt_inc && (mispredict_cnt_q != {CNT_W{1'b1}}))
      mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mispredict_cnt_q <= '0;
    else        mispredict_cnt_q <= mispredict_cnt_d;
  end

  assign bus.pred_taken     = rd_ctr[1];
  assign bus.redirect       = redirect_c;
  assign bus.flush          = redirect_c;
  assign bus.redirect_pc    = redirect_pc_c;
  assign bus.mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Directed-vector bench for branch_resolve_bht with a queue-based scoreboard.
module tb_branch_resolve_bht;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned CNT_W = 2;
  localparam logic [63:0] ALL1  = '1;

  logic clk;
  logic rst_n;

  branch_resolve_bht_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  branch_resolve_bht #(
    .XLEN        (XLEN),
    .BHT_ENTRIES (64),
    .CNT_W       (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        redir;
    logic [63:0] pc;
    logic        pred;
    logic [1:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input string fld,
                     input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
  endtask

  // Monitor: outputs are combinational, so each vector is checked mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, "redirect",    64'(bus.redirect),       64'(e.redir));
      chk(e.name, "flush",       64'(bus.flush),          64'(e.redir));
      chk(e.name, "redirect_pc", bus.redirect_pc,         e.pc);
      chk(e.name, "pred_taken",  64'(bus.pred_taken),     64'(e.pred));
      chk(e.name, "cnt",         64'(bus.mispredict_cnt), 64'(e.cnt));
    end
  end

  task automatic vec(input logic rst, input logic v, input logic br, input logic jp,
                     input logic [2:0] f3, input logic [63:0] rs1, input logic [63:0] rs2,
                     input logic [63:0] pc, input logic [63:0] tgt, input logic pt,
                     input logic hz, input logic [63:0] ifpc, input string nm,
                     input logic er, input logic [63:0] epc, input logic ep,
                     input logic [1:0] ec);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n             = rst;
    bus.ex_valid      = v;
    bus.ex_branch     = br;
    bus.ex_jump       = jp;
    bus.ex_funct3     = f3;
    bus.ex_rs1        = rs1;
    bus.ex_rs2        = rs2;
    bus.ex_pc         = pc;
    bus.ex_target     = tgt;
    bus.ex_pred_taken = pt;
    bus.hazard        = hz;
    bus.if_pc         = ifpc;
    e.name = nm; e.redir = er; e.pc = epc; e.pred = ep; e.cnt = ec;
    exp_q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.ex_valid = 0; bus.ex_branch = 0; bus.ex_jump = 0; bus.ex_funct3 = 0;
    bus.ex_rs1 = 0; bus.ex_rs2 = 0; bus.ex_pc = 0; bus.ex_target = 0;
    bus.ex_pred_taken = 0; bus.hazard = 0; bus.if_pc = 0;

    //   rst v br jp f3      rs1   rs2   pc      tgt     pt hz if_pc   name         redir pc      pred cnt
    vec(0, 1, 0, 1, 3'b000, 0,    0,    64'h40, 64'h2000, 0, 0, 64'h1000, "in_reset",   0, 64'h0,    0, 0);
    vec(1, 0, 0, 0, 3'b000, 0,    0,    64'h0,  64'h0,    0, 0, 64'h1000, "idle",       0, 64'h4,    0, 0);
    vec(1, 1, 1, 0, 3'b000, 5,    5,    64'h1000, 64'h0F00, 0, 0, 64'h1000, "beq_t1",   1, 64'h0F00, 0, 0);
    vec(1, 1, 1, 0, 3'b000, 5,    5,    64'h1000, 64'h0F00, 1, 0, 64'h1000, "beq_t2",   0, 64'h1004, 1, 1);
    vec(1, 1, 1, 0, 3'b000, 5,    5,    64'h1000, 64'h0F00, 1, 0, 64'h1000, "beq_t3",   0, 64'h1004, 1, 1);
    vec(1, 0, 0, 0, 3'b000, 0,    0,    64'h1000, 64'h0,    0, 0, 64'h1000, "trained",  0, 64'h1004, 1, 1);
    vec(1, 1, 1, 0, 3'b100, ALL1, 1,    64'h3004, 64'h3100, 0, 0, 64'h1000, "blt",      1, 64'h3100, 1, 1);
    vec(1, 1, 1, 0, 3'b110, ALL1, 1,    64'h3004, 64'h3100, 0, 0, 64'h1000, "bltu",     0, 64'h3008, 1, 2);
    vec(1, 1, 0, 1, 3'b000, 0,    0,    64'h4000, 64'h2000, 0, 0, 64'h3004, "jal",      1, 64'h2000, 0, 2);
    vec(1, 1, 1, 0, 3'b010, 5,    5,    64'h3004, 64'h3100, 0, 0, 64'h3004, "f3_010",   0, 64'h3008, 0, 2);
    vec(1, 1, 1, 0, 3'b000, 7,    7,    64'h3004, 64'h3100, 0, 1, 64'h3004, "hazard",   0, 64'h3008, 0, 2);
    vec(1, 1, 1, 0, 3'b000, 7,    7,    64'h3004, 64'h3100, 0, 0, 64'h3004, "unhazard", 1, 64'h3100, 0, 2);
    vec(1, 0, 0, 0, 3'b000, 0,    0,    64'h3004, 64'h0,    0, 0, 64'h3004, "post_upd", 0, 64'h3008, 1, 3);
    vec(1, 1, 1, 0, 3'b111, 1,    ALL1, 64'h3004, 64'h3100, 1, 0, 64'h3004, "bgeu_nt",  1, 64'h3008, 1, 3);
    vec(1, 1, 1, 0, 3'b001, 5,    6,    64'h3004, 64'h3100, 0, 0, 64'h3004, "bne_sat",  1, 64'h3100, 0, 3);
    vec(1, 0, 0, 0, 3'b000, 0,    0,    64'h3004, 64'h0,    0, 0, 64'h3107, "alias",    0, 64'h3008, 1, 3);
    vec(0, 1, 1, 0, 3'b001, 5,    6,    64'h3004, 64'h3100, 0, 0, 64'h3004, "mid_rst",  0, 64'h0,    0, 0);
    vec(1, 0, 0, 0, 3'b000, 0,    0,    64'h3004, 64'h0,    0, 0, 64'h3004, "after_rst",0, 64'h3008, 0, 0);
    vec(1, 0, 0, 0, 3'b000, 0,    0,    64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 0, 0, 64'h1000, "pc_wrap", 0, 64'h0, 0, 0);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain actual=%0d pending required=0 pending", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
